// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous waveform in clk cycles,
// with lock and timeout flags. Define CLK_PERIOD_METER_DUTY_CHECK_EN to add duty_ok.
module clk_period_meter #(
  parameter int CNT_W       = 8,
  parameter int LOCK_CNT    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
`ifdef CLK_PERIOD_METER_DUTY_CHECK_EN
  output logic             duty_ok,
`endif
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [3:0]       LC_MAX  = 4'(LOCK_CNT);

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s_d_reg;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [CNT_W-1:0]       hcnt_reg, hcnt_next;
  logic [CNT_W-1:0]       high_tmp_reg, high_tmp_next;
  logic                   high_seen_reg, high_seen_next;
  logic [CNT_W-1:0]       period_reg, period_next;
  logic [CNT_W-1:0]       high_reg, high_next;
  logic                   mv_reg, mv_next;
  logic [3:0]             lc_reg, lc_next;
  logic                   locked_reg, locked_next;
  logic                   timeout_reg, timeout_next;
  logic                   s, rise, fall;

  assign s    = sync_reg[SYNC_STAGES-1];
  assign rise = s & ~s_d_reg;
  assign fall = ~s & s_d_reg;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    hcnt_next      = hcnt_reg;
    high_tmp_next  = high_tmp_reg;
    high_seen_next = high_seen_reg;
    period_next    = period_reg;
    high_next      = high_reg;
    mv_next        = 1'b0;
    lc_next        = lc_reg;
    timeout_next   = timeout_reg;
    locked_next    = (lc_reg == LC_MAX);
    case (state_reg)
      IDLE: begin
        cnt_next  = '0;
        hcnt_next = '0;
        if (rise) begin
          cnt_next       = CNT_ONE;
          hcnt_next      = CNT_ONE;
          high_seen_next = 1'b0;
          state_next     = ARMED;
        end
      end
      ARMED, RUN: begin
        if (rise) begin
          cnt_next       = CNT_ONE;
          hcnt_next      = CNT_ONE;
          high_seen_next = 1'b0;
          state_next     = RUN;
          if (state_reg == RUN) begin
            period_next = cnt_reg;
            high_next   = high_seen_reg ? high_tmp_reg : '0;
            mv_next     = 1'b1;
            // lc is only zero right after reset or timeout: first measurement
            if (lc_reg == 4'd0 || cnt_reg != period_reg)
              lc_next = 4'd1;
            else if (lc_reg >= LC_MAX)
              lc_next = LC_MAX;
            else
              lc_next = lc_reg + 4'd1;
          end
        end else if (cnt_reg == CNT_MAX) begin
          timeout_next = 1'b1;
          lc_next      = 4'd0;
          locked_next  = 1'b0;
          cnt_next     = '0;
          hcnt_next    = '0;
          state_next   = IDLE;
        end else begin
          cnt_next  = cnt_reg + CNT_ONE;
          hcnt_next = hcnt_reg + CNT_ONE;
          if (fall) begin
            high_tmp_next  = hcnt_reg;
            high_seen_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sync_reg      <= '0;
      s_d_reg       <= 1'b0;
      cnt_reg       <= '0;
      hcnt_reg      <= '0;
      high_tmp_reg  <= '0;
      high_seen_reg <= 1'b0;
      period_reg    <= '0;
      high_reg      <= '0;
      mv_reg        <= 1'b0;
      lc_reg        <= 4'd0;
      locked_reg    <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sync_reg      <= {sync_reg[SYNC_STAGES-2:0], sig_in};
      s_d_reg       <= s;
      cnt_reg       <= cnt_next;
      hcnt_reg      <= hcnt_next;
      high_tmp_reg  <= high_tmp_next;
      high_seen_reg <= high_seen_next;
      period_reg    <= period_next;
      high_reg      <= high_next;
      mv_reg        <= mv_next;
      lc_reg        <= lc_next;
      locked_reg    <= locked_next;
      timeout_reg   <= timeout_next;
    end
  end

  assign period     = period_reg;
  assign high_time  = high_reg;
  assign meas_valid = mv_reg;
  assign locked     = locked_reg;
  assign timeout    = timeout_reg;

`ifdef CLK_PERIOD_METER_DUTY_CHECK_EN
  // One extra bit so 2*high_time cannot overflow for odd-period tolerance
  logic [CNT_W:0] two_h, p_ext, diff;
  logic           duty_reg;
  assign two_h = {high_next, 1'b0};
  assign p_ext = {1'b0, period_next};
  assign diff  = (two_h >= p_ext) ? (two_h - p_ext) : (p_ext - two_h);

  always_ff @(posedge clk) begin
    if (rst)
      duty_reg <= 1'b0;
    else if (mv_next)
      duty_reg <= (diff <= (CNT_W+1)'(1));
  end
  assign duty_ok = duty_reg;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: edge-time reference model, table
// vectors, directed corner sequences and randomized waveforms.
module tb_clk_period_meter;
  localparam int CNT_W       = 8;
  localparam int LOCK_CNT    = 4;
  localparam int SYNC_STAGES = 2;
  localparam int TMAX        = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             sig_in;
  logic [CNT_W-1:0] period, high_time;
  logic             meas_valid, locked, timeout;
`ifdef CLK_PERIOD_METER_DUTY_CHECK_EN
  logic             duty_ok;
`endif

  clk_period_meter #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in),
    .period(period), .high_time(high_time), .meas_valid(meas_valid),
    .locked(locked),
`ifdef CLK_PERIOD_METER_DUTY_CHECK_EN
    .duty_ok(duty_ok),
`endif
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mv_seen = 0;

  // Reference model: events are (edge index, level) of the synchronized input
  typedef struct { int t; bit v; } ev_t;
  ev_t evq[$];
  int  cyc = 0;
  int  phase = 0;         // 0 idle, 1 waiting first full period, 2 measuring
  int  t_last = 0, fall_t = 0;
  bit  fall_seen = 0, first_meas = 0, last_level = 0;
  int  m_period = 0, m_high = 0, m_lc = 0;
  bit  m_mv = 0, m_locked = 0, m_timeout = 0, m_duty = 0;

  task automatic model_edge(input bit r, input bit v);
    bit rise, fall, nl;
    int prev, d;
    ev_t e;
    cyc++;
    if (r) begin
      phase = 0; m_period = 0; m_high = 0; m_lc = 0; m_mv = 0; m_locked = 0;
      m_timeout = 0; m_duty = 0; fall_seen = 0; last_level = 0;
      evq.delete();
      return;
    end
    rise = 0; fall = 0;
    nl = (m_lc == LOCK_CNT);
    m_mv = 0;
    while (evq.size() > 0 && evq[0].t == cyc) begin
      e = evq.pop_front();
      if (e.v) rise = 1; else fall = 1;
    end
    if (rise) begin
      if (phase == 2) begin
        prev     = m_period;
        m_period = cyc - t_last;
        m_high   = fall_seen ? fall_t - t_last : 0;
        m_mv     = 1;
        if (first_meas || m_period != prev) m_lc = 1;
        else m_lc = (m_lc >= LOCK_CNT) ? LOCK_CNT : m_lc + 1;
        first_meas = 0;
        d = 2 * m_high - m_period;
        m_duty = (d >= -1 && d <= 1);
      end
      if (phase == 0) begin phase = 1; first_meas = 1; end
      else phase = 2;
      t_last = cyc;
      fall_seen = 0;
    end else if (phase != 0 && cyc - t_last >= TMAX) begin
      m_timeout = 1; m_lc = 0; nl = 0; phase = 0;
    end else if (fall && phase != 0) begin
      fall_seen = 1; fall_t = cyc;
    end
    m_locked = nl;
    if (v != last_level) begin
      evq.push_back('{cyc + SYNC_STAGES, v});
      last_level = v;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic compare_cycle();
    int act, exp;
    act = {period, high_time, meas_valid, locked, timeout};
    exp = {m_period[CNT_W-1:0], m_high[CNT_W-1:0], m_mv, m_locked, m_timeout};
`ifdef CLK_PERIOD_METER_DUTY_CHECK_EN
    act = {act[30:0], duty_ok};
    exp = {exp[30:0], m_duty};
`endif
    check("outputs{period,high,mv,locked,timeout}", act, exp);
    if (meas_valid === 1'b1) begin
      mv_seen++;
      $display("MEAS cycle %0d period %0d high %0d locked %0b timeout %0b",
               cyc, period, high_time, locked, timeout);
    end
  endtask

  task automatic step(input bit r, input bit v);
    rst = r;
    sig_in = v;
    @(posedge clk);
    model_edge(r, v);
    #1;
    compare_cycle();
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    for (int k = 0; k < reps; k++) begin
      for (int j = 0; j < hi; j++) step(1'b0, 1'b1);
      for (int j = 0; j < lo; j++) step(1'b0, 1'b0);
    end
  endtask

  typedef struct { int hi; int lo; int reps; int per; int hgh; bit lck; bit duty; } vec_t;
  vec_t tbl[3];

  initial begin
    tbl[0] = '{2, 1, 10, 3, 2, 1'b1, 1'b1};
    tbl[1] = '{3, 3, 6,  6, 3, 1'b1, 1'b1};
    tbl[2] = '{1, 3, 6,  4, 1, 1'b1, 1'b0};

    // Reset with input toggling: outputs must stay cleared
    for (int i = 0; i < 3; i++) step(1'b1, i[0]);
    check("reset_period", int'(period), 0);
    check("reset_timeout", int'(timeout), 0);

    foreach (tbl[i]) begin
      wave(tbl[i].hi, tbl[i].lo, tbl[i].reps);
      for (int j = 0; j < 3; j++) step(1'b0, 1'b0);
      check("tbl_period", int'(period), tbl[i].per);
      check("tbl_high", int'(high_time), tbl[i].hgh);
      check("tbl_locked", int'(locked), int'(tbl[i].lck));
`ifdef CLK_PERIOD_METER_DUTY_CHECK_EN
      check("tbl_duty", int'(duty_ok), int'(tbl[i].duty));
`endif
    end

    // Stuck low: timeout after 2^CNT_W-1 cycles, period holds
    for (int j = 0; j < 300; j++) step(1'b0, 1'b0);
    check("to_timeout", int'(timeout), 1);
    check("to_locked", int'(locked), 0);
    check("to_period_hold", int'(period), 4);
    wave(2, 1, 6);
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0);
    check("to_sticky", int'(timeout), 1);
    check("to_resume_period", int'(period), 3);

    // Reset two cycles after a rise while measuring
    step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b0);
    step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);
    step(1'b0, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b0);
    check("mid_rst_period", int'(period), 0);
    check("mid_rst_timeout", int'(timeout), 0);
    mv_seen = 0;
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    wave(2, 1, 2);
    check("mid_rst_no_meas", mv_seen, 0);
    wave(2, 1, 3);
    check("mid_rst_meas_resumes", int'(mv_seen > 0), 1);

    // Randomized segments, occasional resets and long lows near the timeout
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 9) == 0) begin
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) step(1'b1, 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 11) == 0) begin
        for (int j = 0; j < int'($urandom_range(TMAX - 10, TMAX + 10)); j++) step(1'b0, 1'b0);
      end
      wave($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6));
    end
    for (int j = 0; j < 6; j++) step(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
